// File: rtl/led_chase_pkg.sv
// Shared types and constants for the LED chase controller.
// Holds the FSM state encoding, speed-level limits and the tick period helper.
package led_chase_pkg;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Halving per speed level, floored at one cycle so the fastest levels never stall.
    function automatic int unsigned period_of(input int unsigned base, input logic [SPEED_W-1:0] level);
        int unsigned p;
        p = base >> level;
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running period counter: asserts wrap in the cycle the count reaches period-1.
// Latency: wrap is combinational from the counter; the counter itself is registered.
// Backpressure: none; run gates counting, clear forces the count to zero and masks wrap.
module tick_gen
#(
    parameter int CNT_W = 5
)
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             run,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic             at_end;

    assign at_end = (cnt_q >= (period - CNT_ONE));
    assign wrap   = run && !clear && at_end;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= at_end ? '0 : cnt_q + CNT_ONE;
        end
    end

endmodule

// File: rtl/led_chase_ctrl.sv
// LED chase controller: run/pause FSM, 8-level speed register and registered advance strobe.
// Latency: enable_o rises one cycle after the counter wrap or an accepted step request.
// Backpressure: none; single-cycle input pulses. Macro LED_CHASE_STEP_EN enables single-step.
module led_chase_ctrl
    import led_chase_pkg::*;
#(
    parameter int unsigned BASE_PERIOD   = 25_000_000,
    parameter int unsigned DEFAULT_SPEED = 2
)
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               run_toggle_i,
    input  logic               faster_i,
    input  logic               slower_i,
    input  logic               step_i,
    output logic               enable_o,
    output logic [SPEED_W-1:0] speed_o,
    output logic [1:0]         state_o
);

    localparam int CNT_W = $clog2(BASE_PERIOD + 1);

    state_t             state_q;
    logic [SPEED_W-1:0] speed_q;
    logic [SPEED_W-1:0] speed_nxt;
    logic               enable_q;
    logic               speed_chg;
    logic               run;
    logic               cnt_clear;
    logic               wrap;
    logic               step_fire;
    logic [CNT_W-1:0]   period;

    // Opposing requests in one cycle cancel; saturated requests are no-ops.
    always_comb begin
        speed_nxt = speed_q;
        if (faster_i && !slower_i && speed_q != SPEED_MAX) begin
            speed_nxt = speed_q + SPEED_W'(1);
        end else if (slower_i && !faster_i && speed_q != '0) begin
            speed_nxt = speed_q - SPEED_W'(1);
        end
    end

    assign speed_chg = (speed_nxt != speed_q);
    assign run       = (state_q == ST_RUN);
    // Outside RUN/PAUSE the count is held at zero, so starting from IDLE always begins a fresh period.
    assign cnt_clear = speed_chg || !(run || state_q == ST_PAUSE);
    assign period    = CNT_W'(period_of(BASE_PERIOD, speed_q));

`ifdef LED_CHASE_STEP_EN
    assign step_fire = step_i && !run_toggle_i && (state_q == ST_PAUSE);
`else
    logic unused_step;
    assign unused_step = step_i;
    assign step_fire   = 1'b0;
`endif

    tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .run     (run),
        .clear   (cnt_clear),
        .period  (period),
        .wrap    (wrap)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            speed_q  <= SPEED_W'(DEFAULT_SPEED);
            enable_q <= 1'b0;
        end else begin
            speed_q  <= speed_nxt;
            enable_q <= wrap || step_fire;
            case (state_q)
                ST_IDLE:  if (run_toggle_i) state_q <= ST_RUN;
                ST_RUN:   if (run_toggle_i) state_q <= ST_PAUSE;
                ST_PAUSE: if (run_toggle_i) state_q <= ST_RUN;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign enable_o = enable_q;
    assign speed_o  = speed_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_led_chase_ctrl.sv
// Bench for led_chase_ctrl with BASE_PERIOD=16, DEFAULT_SPEED=1 (period 8 at reset).
// Each cycle queues the expected outputs as inputs are driven and checks them after the edge.
module tb_led_chase_ctrl;

    logic       clk_i;
    logic       reset_i;
    logic       run_toggle_i;
    logic       faster_i;
    logic       slower_i;
    logic       step_i;
    logic       enable_o;
    logic [2:0] speed_o;
    logic [1:0] state_o;

`ifdef LED_CHASE_STEP_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       tg;
        logic       fa;
        logic       sl;
        logic       st;
        logic       en;
        logic [2:0] sp;
        logic [1:0] stt;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[9];
    int   checks   = 0;
    int   failures = 0;

    led_chase_ctrl #(
        .BASE_PERIOD   (16),
        .DEFAULT_SPEED (1)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .run_toggle_i (run_toggle_i),
        .faster_i     (faster_i),
        .slower_i     (slower_i),
        .step_i       (step_i),
        .enable_o     (enable_o),
        .speed_o      (speed_o),
        .state_o      (state_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1);
    end

    function automatic vec_t mk(input logic rst, tg, fa, sl, st, en,
                                input logic [2:0] sp, input logic [1:0] stt);
        vec_t v;
        v.rst = rst; v.tg = tg; v.fa = fa; v.sl = sl; v.st = st;
        v.en = en; v.sp = sp; v.stt = stt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        reset_i      = v.rst;
        run_toggle_i = v.tg;
        faster_i     = v.fa;
        slower_i     = v.sl;
        step_i       = v.st;
        exp_q.push_back(v);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        chk({nm, ".enable"}, {7'd0, enable_o}, {7'd0, e.en});
        chk({nm, ".speed"},  {5'd0, speed_o},  {5'd0, e.sp});
        chk({nm, ".state"},  {6'd0, state_o},  {6'd0, e.stt});
    endtask

    task automatic cyc(input logic rst, tg, fa, sl, st, en,
                       input logic [2:0] sp, input logic [1:0] stt, input string nm);
        apply(mk(rst, tg, fa, sl, st, en, sp, stt), nm);
    endtask

    initial begin
        reset_i = 1'b1; run_toggle_i = 1'b0; faster_i = 1'b0; slower_i = 1'b0; step_i = 1'b0;

        //            rst tg fa sl st  en sp    st
        tbl[0] = mk(1, 0, 0, 0, 0, 0, 3'd1, 2'd0);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 3'd1, 2'd0);
        tbl[2] = mk(0, 0, 1, 0, 0, 0, 3'd2, 2'd0);
        tbl[3] = mk(0, 0, 0, 1, 0, 0, 3'd1, 2'd0);
        tbl[4] = mk(0, 0, 0, 1, 0, 0, 3'd0, 2'd0);
        tbl[5] = mk(0, 0, 0, 1, 0, 0, 3'd0, 2'd0);
        tbl[6] = mk(0, 0, 1, 1, 0, 0, 3'd0, 2'd0);
        tbl[7] = mk(0, 0, 1, 0, 0, 0, 3'd1, 2'd0);
        tbl[8] = mk(0, 0, 0, 0, 1, 0, 3'd1, 2'd0);
        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Start: first pulse exactly one period after the toggle edge.
        cyc(0, 1, 0, 0, 0, 0, 3'd1, 2'd1, "start");
        for (int k = 1; k <= 24; k++)
            cyc(0, 0, 0, 0, 0, (k % 8 == 0), 3'd1, 2'd1, $sformatf("run%0d", k));

        // Pause with the count at 5, hold 20 cycles, resume: 3 cycles to the next pulse.
        for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd1, $sformatf("pre%0d", k));
        cyc(0, 1, 0, 0, 0, 0, 3'd1, 2'd2, "pause5");
        for (int k = 1; k <= 20; k++) cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, $sformatf("hold%0d", k));
        cyc(0, 1, 0, 0, 0, 0, 3'd1, 2'd1, "resume5");
        for (int r = 1; r <= 11; r++)
            cyc(0, 0, 0, 0, 0, (r == 3 || r == 11), 3'd1, 2'd1, $sformatf("res%0d", r));

        // Steps while paused pulse once each and leave the count (1) untouched.
        cyc(0, 1, 0, 0, 0, 0, 3'd1, 2'd2, "pause1");
        cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, "p_a");
        cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, "p_b");
        cyc(0, 0, 0, 0, 1, STEP_EN, 3'd1, 2'd2, "step1");
        cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, "step1_after");
        cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, "p_c");
        cyc(0, 0, 0, 0, 1, STEP_EN, 3'd1, 2'd2, "step2");
        cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, "step2_after");
        cyc(0, 1, 0, 0, 1, 0, 3'd1, 2'd1, "tog_step");
        for (int r = 1; r <= 7; r++)
            cyc(0, 0, 0, 0, (r == 2), (r == 7), 3'd1, 2'd1, $sformatf("after_step%0d", r));

        // Speed change mid-period clears the count: new period 4 starts at the change.
        for (int k = 1; k <= 3; k++) cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd1, $sformatf("mid%0d", k));
        cyc(0, 0, 1, 0, 0, 0, 3'd2, 2'd1, "faster2");
        for (int r = 1; r <= 4; r++)
            cyc(0, 0, 0, 0, 0, (r == 4), 3'd2, 2'd1, $sformatf("p4_%0d", r));

        // Saturate at 7: period 1 gives a continuous strobe; saturated requests do not clear.
        for (int k = 3; k <= 7; k++) cyc(0, 0, 1, 0, 0, 0, 3'(k), 2'd1, $sformatf("fast_to%0d", k));
        for (int k = 1; k <= 10; k++) cyc(0, 0, 0, 0, 0, 1, 3'd7, 2'd1, $sformatf("p1_%0d", k));
        cyc(0, 0, 1, 0, 0, 1, 3'd7, 2'd1, "fast_sat");
        cyc(0, 0, 1, 1, 0, 1, 3'd7, 2'd1, "both_sat");
        cyc(0, 0, 0, 0, 0, 1, 3'd7, 2'd1, "p1_tail");

        // Back to level 1, run to count 6, then reset wins over simultaneous requests.
        for (int k = 6; k >= 1; k--) cyc(0, 0, 0, 1, 0, 0, 3'(k), 2'd1, $sformatf("slow_to%0d", k));
        for (int k = 1; k <= 6; k++) cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd1, $sformatf("to6_%0d", k));
        cyc(1, 1, 1, 0, 0, 0, 3'd1, 2'd0, "reset_mid");
        for (int k = 1; k <= 50; k++) cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd0, $sformatf("post_rst%0d", k));

        // Reset while a step is requested in PAUSE.
        cyc(0, 1, 0, 0, 0, 0, 3'd1, 2'd1, "rerun");
        cyc(0, 1, 0, 0, 0, 0, 3'd1, 2'd2, "repause");
        cyc(1, 0, 0, 0, 1, 0, 3'd1, 2'd0, "reset_step");
        cyc(0, 0, 0, 0, 0, 0, 3'd1, 2'd0, "reset_step_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
